ram1_ctrl: RTL and testbench

Ram1 SRAM access controller placed directly downstream of the zzcpu pipeline. It arbitrates the single Ram1 port between instruction fetch (IF) and the data-memory stage (MEM), and sequences the Ram1EN/OE/WE strobes and the bidirectional data bus. It returns read data and a one-cycle done pulse to the requester, plus a combined stall for the pipeline. MEM has priority over IF, which resolves the IF/MEM structural hazard.

---
 rtl/ram1_ctrl_pkg.sv | 37 +++
 rtl/ram1_data_pad.sv | 15 +
 rtl/ram1_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ram1_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ram1_ctrl_pkg.sv
// Shared types and constants for the Ram1 SRAM access controller.
// Holds the FSM state encoding, requester ids and bus-idle strobe levels.
package ram1_ctrl_pkg;

  localparam int unsigned CPU_ADDR_W = 16;
  localparam int unsigned WE_CNT_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam logic SRC_IF  = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  // Active-low SRAM strobes, bundled so they register together
  typedef struct packed {
    logic en;
    logic oe;
    logic we;
  } strobe_t;

  localparam logic EN_IDLE = 1'b1;
  localparam logic OE_IDLE = 1'b1;
  localparam logic WE_IDLE = 1'b1;

  localparam strobe_t STROBE_IDLE = '{en: EN_IDLE, oe: OE_IDLE, we: WE_IDLE};

  function automatic logic is_wr_state(input state_e s);
    return (s == ST_WR_SETUP) || (s == ST_WR_PULSE) || (s == ST_WR_HOLD);
  endfunction

endpackage

// File: rtl/ram1_data_pad.sv
// Tri-state driver for the Ram1 data bus: drives write data when enabled,
// always returns the pad value on the input path.
module ram1_data_pad #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_drive_en,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  inout  wire  [DATA_W-1:0] io_pad
);

  assign io_pad  = i_drive_en ? i_wdata : {DATA_W{1'bz}};
  assign o_rdata = io_pad;

endmodule

// File: rtl/ram1_ctrl.sv
// Ram1 SRAM access controller: arbitrates IF and MEM onto the single Ram1 port
// (MEM first), sequences EN/OE/WE and the data bus, and returns data plus done.
module ram1_ctrl
  import ram1_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned WE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [CPU_ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_done,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [CPU_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_done,
  output logic                  stall,
  output logic [ADDR_W-1:0]     Ram1Addr,
  inout  wire  [DATA_W-1:0]     Ram1Data,
  output logic                  Ram1OE,
  output logic                  Ram1WE,
  output logic                  Ram1EN
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_src;
  logic                  w_src_nxt;
  logic [CPU_ADDR_W-1:0] r_addr_q;
  logic [CPU_ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0]     r_wdata_q;
  logic [DATA_W-1:0]     w_wdata_nxt;
  logic [DATA_W-1:0]     r_rdata_q;
  logic [DATA_W-1:0]     w_rdata_nxt;
  logic [WE_CNT_W-1:0]   r_we_cnt;
  logic [WE_CNT_W-1:0]   w_we_cnt_nxt;

  strobe_t               r_strobe;
  strobe_t               w_strobe_nxt;
  logic                  r_drive;
  logic                  w_drive_nxt;
  logic [ADDR_W-1:0]     r_ram_addr;
  logic [ADDR_W-1:0]     w_ram_addr_nxt;
  logic                  r_if_done;
  logic                  w_if_done_nxt;
  logic                  r_mem_done;
  logic                  w_mem_done_nxt;

  logic [DATA_W-1:0]     w_pad_rdata;

  ram1_data_pad #(
    .DATA_W (DATA_W)
  ) u_pad (
    .i_drive_en (r_drive),
    .i_wdata    (r_wdata_q),
    .o_rdata    (w_pad_rdata),
    .io_pad     (Ram1Data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_src      <= SRC_IF;
      r_addr_q   <= '0;
      r_wdata_q  <= '0;
      r_rdata_q  <= '0;
      r_we_cnt   <= '0;
      r_strobe   <= STROBE_IDLE;
      r_drive    <= 1'b0;
      r_ram_addr <= '0;
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_src      <= w_src_nxt;
      r_addr_q   <= w_addr_nxt;
      r_wdata_q  <= w_wdata_nxt;
      r_rdata_q  <= w_rdata_nxt;
      r_we_cnt   <= w_we_cnt_nxt;
      r_strobe   <= w_strobe_nxt;
      r_drive    <= w_drive_nxt;
      r_ram_addr <= w_ram_addr_nxt;
      r_if_done  <= w_if_done_nxt;
      r_mem_done <= w_mem_done_nxt;
    end
  end

  // Next state, then pin levels decoded from the next state so they register glitch-free
  always_comb begin
    w_state_nxt    = r_state;
    w_src_nxt      = r_src;
    w_addr_nxt     = r_addr_q;
    w_wdata_nxt    = r_wdata_q;
    w_rdata_nxt    = r_rdata_q;
    w_we_cnt_nxt   = r_we_cnt;
    w_strobe_nxt   = STROBE_IDLE;
    w_drive_nxt    = 1'b0;
    w_ram_addr_nxt = '0;
    w_if_done_nxt  = 1'b0;
    w_mem_done_nxt = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (mem_wr) begin
          w_state_nxt = ST_WR_SETUP;
          w_src_nxt   = SRC_MEM;
          w_addr_nxt  = mem_addr;
          w_wdata_nxt = mem_wdata;
        end else if (mem_rd) begin
          w_state_nxt = ST_RD;
          w_src_nxt   = SRC_MEM;
          w_addr_nxt  = mem_addr;
        end else if (if_req) begin
          w_state_nxt = ST_RD;
          w_src_nxt   = SRC_IF;
          w_addr_nxt  = if_addr;
        end
      end
      ST_RD: begin
        w_rdata_nxt = w_pad_rdata;
        w_state_nxt = ST_DONE;
      end
      ST_WR_SETUP: begin
        w_we_cnt_nxt = WE_CNT_W'(WE_CYCLES - 1);
        w_state_nxt  = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (r_we_cnt != '0) begin
          w_we_cnt_nxt = r_we_cnt - WE_CNT_W'(1);
        end else begin
          w_state_nxt = ST_WR_HOLD;
        end
      end
      ST_WR_HOLD: w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase

    unique case (w_state_nxt)
      ST_RD: begin
        w_strobe_nxt.en = 1'b0;
        w_strobe_nxt.oe = 1'b0;
      end
      ST_WR_PULSE: begin
        w_strobe_nxt.en = 1'b0;
        w_strobe_nxt.we = 1'b0;
      end
      ST_WR_SETUP, ST_WR_HOLD: w_strobe_nxt.en = 1'b0;
      ST_DONE: begin
        w_if_done_nxt  = (w_src_nxt == SRC_IF);
        w_mem_done_nxt = (w_src_nxt == SRC_MEM);
      end
      default: ;
    endcase

    w_drive_nxt = is_wr_state(w_state_nxt);
    if ((w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE)) begin
      w_ram_addr_nxt = ADDR_W'(w_addr_nxt);
    end
  end

  assign if_rdata  = r_rdata_q;
  assign mem_rdata = r_rdata_q;
  assign if_done   = r_if_done;
  assign mem_done  = r_mem_done;
  assign Ram1Addr  = r_ram_addr;
  assign Ram1EN    = r_strobe.en;
  assign Ram1OE    = r_strobe.oe;
  assign Ram1WE    = r_strobe.we;

  // Pipeline stall straight from the live requests so it rises the same cycle
  assign stall = (if_req & ~r_if_done) | ((mem_rd | mem_wr) & ~r_mem_done);

endmodule

// File: tb/tb_ram1_ctrl.sv
// Directed bench for ram1_ctrl: instance A (1-cycle WE) and instance B (3-cycle WE),
// each attached to a simple asynchronous SRAM model.
module tb_ram1_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic        a_if_req, a_if_done, a_mem_rd, a_mem_wr, a_mem_done, a_stall;
  logic [15:0] a_if_addr, a_if_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [17:0] a_addr;
  wire  [15:0] a_data;
  logic        a_oe, a_we, a_en;

  logic        b_if_req, b_if_done, b_mem_rd, b_mem_wr, b_mem_done, b_stall;
  logic [15:0] b_if_addr, b_if_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [17:0] b_addr;
  wire  [15:0] b_data;
  logic        b_oe, b_we, b_en;

  logic [15:0] sram_a [0:262143];
  logic [15:0] sram_b [0:262143];

  ram1_ctrl #(.ADDR_W(18), .DATA_W(16), .WE_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_done(a_if_done),
    .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .mem_done(a_mem_done), .stall(a_stall),
    .Ram1Addr(a_addr), .Ram1Data(a_data), .Ram1OE(a_oe), .Ram1WE(a_we), .Ram1EN(a_en)
  );

  ram1_ctrl #(.ADDR_W(18), .DATA_W(16), .WE_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_done(b_if_done),
    .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_done(b_mem_done), .stall(b_stall),
    .Ram1Addr(b_addr), .Ram1Data(b_data), .Ram1OE(b_oe), .Ram1WE(b_we), .Ram1EN(b_en)
  );

  // SRAM models: drive on EN&OE low, store on any clock edge seen with EN&WE low
  assign a_data = (!a_en && !a_oe) ? sram_a[a_addr] : 16'hzzzz;
  assign b_data = (!b_en && !b_oe) ? sram_b[b_addr] : 16'hzzzz;

  always @(posedge clk) begin
    if (rst) sram_a[18'h4] <= 16'h6C04;
    else if (!a_en && !a_we) sram_a[a_addr] <= a_data;
  end

  always @(posedge clk) begin
    if (!b_en && !b_we) sram_b[b_addr] <= b_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe one access for 12 cycles from the acceptance edge; drops requests at done
  task automatic measure(input bit sel, output int done_cyc, output int done_cnt,
                         output int we_low, output int oe_low, output int bad_bus,
                         output logic [15:0] rd_val, output logic stall_d,
                         output logic [2:0] first_str, output logic [15:0] first_bus,
                         output logic [17:0] first_addr);
    logic        en, oe, we, dn, st;
    logic [15:0] bus, model, rv;
    logic [17:0] ad;
    done_cyc = 0; done_cnt = 0; we_low = 0; oe_low = 0; bad_bus = 0;
    rd_val = '0; stall_d = 1'b1; first_str = '0; first_bus = '0; first_addr = '0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (!sel) begin
        en = a_en; oe = a_oe; we = a_we; bus = a_data; ad = a_addr; model = sram_a[a_addr];
        dn = a_if_done | a_mem_done; st = a_stall; rv = a_mem_done ? a_mem_rdata : a_if_rdata;
      end else begin
        en = b_en; oe = b_oe; we = b_we; bus = b_data; ad = b_addr; model = sram_b[b_addr];
        dn = b_if_done | b_mem_done; st = b_stall; rv = b_mem_done ? b_mem_rdata : b_if_rdata;
      end
      if (c == 1) begin first_str = {en, oe, we}; first_bus = bus; first_addr = ad; end
      if (!we) we_low++;
      if (!oe) begin
        oe_low++;
        if (bus !== model) bad_bus++;
      end
      if (!oe && !we) bad_bus++;
      if (dn) begin
        done_cnt++;
        if (done_cyc == 0) begin done_cyc = c; rd_val = rv; stall_d = st; end
        if (!sel) begin a_if_req = 1'b0; a_mem_rd = 1'b0; a_mem_wr = 1'b0; end
        else      begin b_if_req = 1'b0; b_mem_rd = 1'b0; b_mem_wr = 1'b0; end
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++; if (a_if_rdata !== 16'h0 || a_mem_rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata: if=%h mem=%h want 0000", a_if_rdata, a_mem_rdata); end
    total++; if (a_if_done !== 1'b0 || a_mem_done !== 1'b0) begin bad++; $display("FAIL reset_done: if=%b mem=%b want 0", a_if_done, a_mem_done); end
    total++; if ({a_en, a_oe, a_we} !== 3'b111) begin bad++; $display("FAIL reset_strobes: got %b want 111", {a_en, a_oe, a_we}); end
    total++; if (a_addr !== 18'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", a_addr); end
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", a_stall); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_if_read();
    int dc, dn, wl, ol, bb; logic [15:0] rv, fb; logic sd; logic [2:0] fs; logic [17:0] fa;
    a_if_req = 1'b1; a_if_addr = 16'h0004;
    #1;
    total++; if (a_stall !== 1'b1) begin bad++; $display("FAIL if_stall_rise: got %b want 1", a_stall); end
    measure(1'b0, dc, dn, wl, ol, bb, rv, sd, fs, fb, fa);
    total++; if (fs !== 3'b001 || fa !== 18'h4) begin bad++; $display("FAIL if_rd_cycle: str=%b addr=%h want 001/00004", fs, fa); end
    total++; if (dc !== 2 || dn !== 1) begin bad++; $display("FAIL if_latency: done_cyc=%0d cnt=%0d want 2/1", dc, dn); end
    total++; if (rv !== 16'h6C04) begin bad++; $display("FAIL if_rdata: got %h want 6c04", rv); end
    total++; if (sd !== 1'b0) begin bad++; $display("FAIL if_stall_done: got %b want 0", sd); end
    total++; if (ol !== 1 || wl !== 0 || bb !== 0) begin bad++; $display("FAIL if_strobes: oe_low=%0d we_low=%0d bus_err=%0d want 1/0/0", ol, wl, bb); end
  endtask

  task automatic test_write();
    int dc, dn, wl, ol, bb; logic [15:0] rv, fb; logic sd; logic [2:0] fs; logic [17:0] fa;
    a_mem_wr = 1'b1; a_mem_addr = 16'h00BF; a_mem_wdata = 16'h1234;
    measure(1'b0, dc, dn, wl, ol, bb, rv, sd, fs, fb, fa);
    total++; if (fs !== 3'b011 || fb !== 16'h1234 || fa !== 18'hBF) begin bad++; $display("FAIL wr_setup: str=%b bus=%h addr=%h want 011/1234/000bf", fs, fb, fa); end
    total++; if (wl !== 1 || ol !== 0) begin bad++; $display("FAIL wr_pulse: we_low=%0d oe_low=%0d want 1/0", wl, ol); end
    total++; if (dc !== 4 || dn !== 1) begin bad++; $display("FAIL wr_latency: done_cyc=%0d cnt=%0d want 4/1", dc, dn); end
    total++; if (sram_a[18'hBF] !== 16'h1234) begin bad++; $display("FAIL wr_sram: got %h want 1234", sram_a[18'hBF]); end
  endtask

  task automatic test_priority();
    int dc, stall_drops; logic [15:0] rv;
    a_if_req = 1'b1; a_if_addr = 16'h0004;
    a_mem_rd = 1'b1; a_mem_addr = 16'h00BF;
    @(posedge clk); #1;
    total++; if (a_addr !== 18'hBF || a_oe !== 1'b0) begin bad++; $display("FAIL prio_grant: addr=%h oe=%b want 000bf/0", a_addr, a_oe); end
    @(posedge clk); #1;
    total++; if (a_mem_done !== 1'b1 || a_if_done !== 1'b0 || a_mem_rdata !== 16'h1234) begin bad++; $display("FAIL prio_mem_done: mem_done=%b if_done=%b rdata=%h want 1/0/1234", a_mem_done, a_if_done, a_mem_rdata); end
    total++; if (a_stall !== 1'b1) begin bad++; $display("FAIL prio_stall_mem: got %b want 1", a_stall); end
    a_mem_rd = 1'b0;
    dc = 0; stall_drops = 0; rv = '0;
    for (int c = 3; c <= 12 && dc == 0; c++) begin
      @(posedge clk); #1;
      if (a_if_done) begin dc = c; rv = a_if_rdata; a_if_req = 1'b0; end
      else if (a_stall !== 1'b1) stall_drops++;
    end
    total++; if (dc !== 5 || rv !== 16'h6C04) begin bad++; $display("FAIL prio_if_later: done_cyc=%0d rdata=%h want 5/6c04", dc, rv); end
    total++; if (stall_drops !== 0) begin bad++; $display("FAIL prio_stall_hold: drops=%0d want 0", stall_drops); end
    a_if_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_rd_wr_both();
    int dc, dn, wl, ol, bb; logic [15:0] rv, fb; logic sd; logic [2:0] fs; logic [17:0] fa;
    a_mem_rd = 1'b1; a_mem_wr = 1'b1; a_mem_addr = 16'h0033; a_mem_wdata = 16'hA55A;
    measure(1'b0, dc, dn, wl, ol, bb, rv, sd, fs, fb, fa);
    total++; if (ol !== 0 || wl !== 1 || bb !== 0) begin bad++; $display("FAIL both_strobes: oe_low=%0d we_low=%0d bus_err=%0d want 0/1/0", ol, wl, bb); end
    total++; if (dc !== 4 || sram_a[18'h33] !== 16'hA55A) begin bad++; $display("FAIL both_write: done_cyc=%0d sram=%h want 4/a55a", dc, sram_a[18'h33]); end
    total++; if (a_mem_rdata !== 16'h6C04) begin bad++; $display("FAIL both_rdata_hold: got %h want 6c04", a_mem_rdata); end
  endtask

  task automatic test_reset_mid_write();
    int dc, dn, wl, ol, bb; logic [15:0] rv, fb; logic sd; logic [2:0] fs; logic [17:0] fa;
    a_mem_wr = 1'b1; a_mem_addr = 16'h0050; a_mem_wdata = 16'hBEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (a_we !== 1'b0) begin bad++; $display("FAIL rst_pre_pulse: we=%b want 0", a_we); end
    #2 rst = 1'b1;
    #1;
    total++; if ({a_en, a_oe, a_we} !== 3'b111 || a_addr !== 18'h0) begin bad++; $display("FAIL rst_async_strobes: str=%b addr=%h want 111/0", {a_en, a_oe, a_we}, a_addr); end
    total++; if (a_data === 16'hBEEF) begin bad++; $display("FAIL rst_async_bus: got %h want released", a_data); end
    total++; if (a_mem_done !== 1'b0 || a_mem_rdata !== 16'h0) begin bad++; $display("FAIL rst_async_regs: done=%b rdata=%h want 0/0000", a_mem_done, a_mem_rdata); end
    a_mem_wr = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    a_if_req = 1'b1; a_if_addr = 16'h0004;
    measure(1'b0, dc, dn, wl, ol, bb, rv, sd, fs, fb, fa);
    total++; if (fs !== 3'b001 || dc !== 2 || rv !== 16'h6C04) begin bad++; $display("FAIL rst_restart: str=%b done_cyc=%0d rdata=%h want 001/2/6c04", fs, dc, rv); end
  endtask

  task automatic test_we3();
    int dc, dn, wl, ol, bb; logic [15:0] rv, fb; logic sd; logic [2:0] fs; logic [17:0] fa;
    b_mem_wr = 1'b1; b_mem_addr = 16'h0077; b_mem_wdata = 16'hC3C3;
    measure(1'b1, dc, dn, wl, ol, bb, rv, sd, fs, fb, fa);
    total++; if (wl !== 3 || ol !== 0 || bb !== 0) begin bad++; $display("FAIL we3_pulse: we_low=%0d oe_low=%0d bus_err=%0d want 3/0/0", wl, ol, bb); end
    total++; if (dc !== 6 || dn !== 1) begin bad++; $display("FAIL we3_latency: done_cyc=%0d cnt=%0d want 6/1", dc, dn); end
    b_mem_rd = 1'b1; b_mem_addr = 16'h0077;
    measure(1'b1, dc, dn, wl, ol, bb, rv, sd, fs, fb, fa);
    total++; if (dc !== 2 || rv !== 16'hC3C3) begin bad++; $display("FAIL we3_readback: done_cyc=%0d rdata=%h want 2/c3c3", dc, rv); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    a_if_req = 1'b0; a_if_addr = '0; a_mem_rd = 1'b0; a_mem_wr = 1'b0; a_mem_addr = '0; a_mem_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_mem_rd = 1'b0; b_mem_wr = 1'b0; b_mem_addr = '0; b_mem_wdata = '0;
    test_reset();
    test_if_read();
    test_write();
    test_priority();
    test_rd_wr_both();
    test_reset_mid_write();
    test_we3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
